write_reg_sched: RTL and testbench
==================================

// Module: write_reg_sched
// PURPOSE
//  Write-port scheduler for the register-file write path. Arbitrates five writeback
//  requesters (ALU, memory load, link/RA, external source, mult/div) onto the single
//  write port. Drives the 3-bit write-register mux selector and the regfile write enable.
//  Mult/div results are written as a two-beat HI-then-LO sequence.
// PARAMETERS
//  STARVE_LIMIT  4  number of denied sampling edges after which a requester is promoted
// PORTS
//  clk       in   1  clock, rising edge
//  reset     in   1  asynchronous, active-low reset
//  mem_req   in   1  load writeback request (selector code 3'b001)
//  alu_req   in   1  ALU writeback request (3'b000)
//  link_req  in   1  return-address (RA) write request (3'b101)
//  ext_req   in   1  external-source write request (3'b100)
//  md_req    in   1  mult/div HI/LO write request (3'b010 then 3'b011)
//  mem_gnt   out  1  one-cycle grant pulse, load writeback
//  alu_gnt   out  1  one-cycle grant pulse, ALU writeback
//  link_gnt  out  1  one-cycle grant pulse, RA write
//  ext_gnt   out  1  one-cycle grant pulse, external-source write
//  md_gnt    out  1  one-cycle pulse, asserted in the LO beat only
//  wr_sel    out  3  write-register mux selector
//  reg_wr    out  1  register-file write enable
//  busy      out  1  high while a HI/LO sequence occupies the port
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async, low): state=IDLE; wait counters=0; wr_sel=3'b000; all other outputs 0.
//    A HI/LO sequence interrupted by reset is abandoned. md_req must be resubmitted.
//  - Handshake: a requester holds req high until it sees its gnt.
//    Latency: req sampled at edge k -> gnt, wr_sel, reg_wr are visible in the cycle after edge k.
//  - Mask: the requester granted at edge k is ignored when sampling at edge k+1.
//    If its req is still high at edge k+2, that is a new request.
//  - FSM:
//    IDLE -> (single-beat grant) IDLE
//    IDLE -> (md granted) MD_HI -> MD_LO -> IDLE
//  - IDLE with no eligible req: reg_wr=0, wr_sel=3'b000, gnt all 0.
//  - IDLE priority: starving requesters first, then fixed mem > alu > link > ext > md.
//    Among multiple starving requesters, the same fixed order applies.
//  - Single-beat grant: that requester's gnt=1, reg_wr=1, wr_sel=its code, for one cycle.
//  - MD_HI: wr_sel=3'b010, reg_wr=1, busy=1, no gnt.
//  - MD_LO: wr_sel=3'b011, reg_wr=1, busy=1, md_gnt=1.
//  - No other grants are issued while in MD_HI or MD_LO.
//    Requests are still sampled and their wait counters keep advancing.
//  - Wait counters: one per requester, width $clog2(STARVE_LIMIT+1).
//    Increment on each edge where req is sampled high, unmasked, and not granted.
//    Saturate at STARVE_LIMIT; clear when the requester is granted or its req is low.
//    A requester is starving when its counter == STARVE_LIMIT at the sampling edge.
//  - Edges inside MD_HI/MD_LO count as denied edges.
//  - The decision at the last MD_LO edge is the next IDLE decision (no bubble).
//    md is masked at that edge.
//  - Simultaneous req from the requester granted last cycle and from others:
//    the masked requester loses; the others arbitrate normally.
// TESTING
//  1 mem_req=alu_req=1 at edge 0, held until gnt:
//    cycle1 mem_gnt, wr_sel=001, reg_wr=1; cycle2 alu_gnt, wr_sel=000, reg_wr=1; cycle3 reg_wr=0.
//  2 md_req pulse at edge 0, alu_req raised in cycle1:
//    cycle1 wr_sel=010, busy=1; cycle2 wr_sel=011, md_gnt=1, busy=1;
//    cycle3 alu_gnt, wr_sel=000, busy=0.
//  3 mem_req and alu_req re-asserted every cycle, link_req held from edge 0 (STARVE_LIMIT=4):
//    link denied at edges 0-3; link_gnt, wr_sel=101 in the cycle after edge 4.
//  4 link_req and ext_req both starving at the same edge:
//    link granted first (wr_sel=101); ext granted on the next sampling edge (wr_sel=100).
//  5 alu_req held high 4 cycles alone: alu_gnt in cycles 1 and 3 only; reg_wr=0 in cycle 2.
//  6 reset driven low during MD_HI: all outputs 0 immediately, busy=0, no LO beat.
//    After release with no requests: reg_wr stays 0.

Source files
------------

// File: rtl/write_reg_sched.sv
// Write-port scheduler: arbitrates five writeback requesters onto the single
// register-file write port, with a two-beat HI/LO sequence for mult/div results.
//
// state | meaning
// IDLE  | single-beat arbitration each edge
// MD_HI | HI beat of mult/div result on the port
// MD_LO | LO beat on the port; its closing edge is an IDLE-style decision
module write_reg_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_req,
  input  logic       alu_req,
  input  logic       link_req,
  input  logic       ext_req,
  input  logic       md_req,
  output logic       mem_gnt,
  output logic       alu_gnt,
  output logic       link_gnt,
  output logic       ext_gnt,
  output logic       md_gnt,
  output logic [2:0] wr_sel,
  output logic       reg_wr,
  output logic       busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MD_HI = 2'd1,
    MD_LO = 2'd2
  } state_t;

  // Bit order everywhere below: 0 mem, 1 alu, 2 link, 3 ext, 4 md
  state_t          state_q, state_d;
  logic [4:0]      gnt_q, gnt_d;
  logic [2:0]      wr_sel_q, wr_sel_d;
  logic            reg_wr_q, reg_wr_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q [5];
  logic [CW-1:0]   cnt_d [5];

  logic [4:0]      req_v;
  logic [4:0]      elig;
  logic [4:0]      starv;
  logic [4:0]      cand;
  logic [4:0]      pick;
  logic [4:0]      win;

  assign req_v = {md_req, ext_req, link_req, alu_req, mem_req};

  // The requester whose gnt is currently visible is masked for this edge
  assign elig = req_v & ~gnt_q;

  always_comb begin
    starv = '0;
    for (int i = 0; i < 5; i++) begin
      starv[i] = elig[i] && (cnt_q[i] == CNT_MAX);
    end
    cand = (|starv) ? starv : elig;
    pick = cand & (~cand + 5'd1);
  end

  always_comb begin
    state_d  = IDLE;
    gnt_d    = '0;
    wr_sel_d = 3'b000;
    reg_wr_d = 1'b0;
    busy_d   = 1'b0;
    win      = '0;
    case (state_q)
      MD_HI: begin
        state_d  = MD_LO;
        gnt_d    = 5'b10000;
        wr_sel_d = 3'b011;
        reg_wr_d = 1'b1;
        busy_d   = 1'b1;
        win      = 5'b10000;
      end
      default: begin
        win = pick;
        if (pick[4]) begin
          state_d  = MD_HI;
          wr_sel_d = 3'b010;
          reg_wr_d = 1'b1;
          busy_d   = 1'b1;
        end else if (|pick) begin
          gnt_d    = pick;
          reg_wr_d = 1'b1;
          unique case (1'b1)
            pick[0]: wr_sel_d = 3'b001;
            pick[1]: wr_sel_d = 3'b000;
            pick[2]: wr_sel_d = 3'b101;
            pick[3]: wr_sel_d = 3'b100;
            default: wr_sel_d = 3'b000;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      if (win[i] || !req_v[i]) begin
        cnt_d[i] = '0;
      end else if (gnt_q[i] || cnt_q[i] == CNT_MAX) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      wr_sel_q <= 3'b000;
      reg_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      wr_sel_q <= wr_sel_d;
      reg_wr_q <= reg_wr_d;
      busy_q   <= busy_d;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign mem_gnt  = gnt_q[0];
  assign alu_gnt  = gnt_q[1];
  assign link_gnt = gnt_q[2];
  assign ext_gnt  = gnt_q[3];
  assign md_gnt   = gnt_q[4];
  assign wr_sel   = wr_sel_q;
  assign reg_wr   = reg_wr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_write_reg_sched.sv
// Bench for write_reg_sched: directed scenarios plus randomized handshakes
// checked against a cycle-level reference model of the arbitration rules.
module tb_write_reg_sched;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_req, alu_req, link_req, ext_req, md_req;
  logic       mem_gnt, alu_gnt, link_gnt, ext_gnt, md_gnt;
  logic [2:0] wr_sel;
  logic       reg_wr, busy;

  int checks = 0;
  int errors = 0;

  logic [2:0] code_tab [5] = '{3'b001, 3'b000, 3'b101, 3'b100, 3'b010};

  // Reference model state
  int m_phase;
  int m_last;
  int m_wait [5];

  write_reg_sched #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .alu_req(alu_req), .link_req(link_req),
    .ext_req(ext_req), .md_req(md_req),
    .mem_gnt(mem_gnt), .alu_gnt(alu_gnt), .link_gnt(link_gnt),
    .ext_gnt(ext_gnt), .md_gnt(md_gnt),
    .wr_sel(wr_sel), .reg_wr(reg_wr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [4:0] r);
    {md_req, ext_req, link_req, alu_req, mem_req} = r;
  endtask

  // {md,ext,link,alu,mem gnt, wr_sel, reg_wr, busy}
  function automatic logic [9:0] obs();
    return {md_gnt, ext_gnt, link_gnt, alu_gnt, mem_gnt, wr_sel, reg_wr, busy};
  endfunction

  task automatic idle;
    set_req(5'b0);
    tick;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    set_req(5'b00001);
    #12;
    checks++;
    if (obs() !== 10'b0) begin
      errors++;
      $display("FAIL reset_hold obs=%b exp=%b", obs(), 10'b0);
    end
    tick;
    checks++;
    if (obs() !== 10'b0) begin
      errors++;
      $display("FAIL reset_edge obs=%b exp=%b", obs(), 10'b0);
    end
    set_req(5'b0);
    #2 reset = 1'b1;
    tick;
    checks++;
    if (obs() !== 10'b0) begin
      errors++;
      $display("FAIL reset_release obs=%b exp=%b", obs(), 10'b0);
    end
  endtask

  task automatic test_two_reqs;
    set_req(5'b00011);
    tick;
    checks++;
    if (obs() !== {5'b00001, 3'b001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL two_c1 obs=%b exp=%b", obs(), {5'b00001, 3'b001, 1'b1, 1'b0});
    end
    set_req(5'b00010);
    tick;
    checks++;
    if (obs() !== {5'b00010, 3'b000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL two_c2 obs=%b exp=%b", obs(), {5'b00010, 3'b000, 1'b1, 1'b0});
    end
    set_req(5'b0);
    tick;
    checks++;
    if (obs() !== 10'b0) begin
      errors++;
      $display("FAIL two_c3 obs=%b exp=%b", obs(), 10'b0);
    end
    idle;
  endtask

  task automatic test_md_seq;
    set_req(5'b10000);
    tick;
    checks++;
    if (obs() !== {5'b00000, 3'b010, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL md_hi obs=%b exp=%b", obs(), {5'b00000, 3'b010, 1'b1, 1'b1});
    end
    set_req(5'b00010);
    tick;
    checks++;
    if (obs() !== {5'b10000, 3'b011, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL md_lo obs=%b exp=%b", obs(), {5'b10000, 3'b011, 1'b1, 1'b1});
    end
    tick;
    checks++;
    if (obs() !== {5'b00010, 3'b000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL md_next obs=%b exp=%b", obs(), {5'b00010, 3'b000, 1'b1, 1'b0});
    end
    idle;
  endtask

  task automatic test_starve;
    logic [9:0] exp;
    set_req(5'b00111);
    for (int e = 0; e < 5; e++) begin
      tick;
      if (e == 4)          exp = {5'b00100, 3'b101, 1'b1, 1'b0};
      else if (e % 2 == 0) exp = {5'b00001, 3'b001, 1'b1, 1'b0};
      else                 exp = {5'b00010, 3'b000, 1'b1, 1'b0};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL starve_e%0d obs=%b exp=%b", e, obs(), exp);
      end
    end
    idle;
  endtask

  task automatic test_dual_starve;
    set_req(5'b01111);
    for (int e = 0; e < 4; e++) begin
      tick;
      checks++;
      if (link_gnt !== 1'b0 || ext_gnt !== 1'b0) begin
        errors++;
        $display("FAIL dual_wait_e%0d link=%b ext=%b exp 0 0", e, link_gnt, ext_gnt);
      end
    end
    tick;
    checks++;
    if (obs() !== {5'b00100, 3'b101, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dual_link obs=%b exp=%b", obs(), {5'b00100, 3'b101, 1'b1, 1'b0});
    end
    set_req(5'b01011);
    tick;
    checks++;
    if (obs() !== {5'b01000, 3'b100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dual_ext obs=%b exp=%b", obs(), {5'b01000, 3'b100, 1'b1, 1'b0});
    end
    idle;
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp;
    set_req(5'b00010);
    for (int c = 0; c < 4; c++) begin
      tick;
      exp = (c % 2 == 0) ? {5'b00010, 3'b000, 1'b1, 1'b0} : 10'b0;
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL mask_c%0d obs=%b exp=%b", c + 1, obs(), exp);
      end
    end
    idle;
  endtask

  task automatic test_reset_md;
    set_req(5'b10000);
    tick;
    checks++;
    if (busy !== 1'b1 || wr_sel !== 3'b010) begin
      errors++;
      $display("FAIL rmd_hi busy=%b sel=%b exp 1 010", busy, wr_sel);
    end
    set_req(5'b0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 10'b0) begin
      errors++;
      $display("FAIL rmd_async obs=%b exp=%b", obs(), 10'b0);
    end
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (obs() !== 10'b0) begin
        errors++;
        $display("FAIL rmd_after_c%0d obs=%b exp=%b", c, obs(), 10'b0);
      end
    end
  endtask

  // Applies the arbitration rules to one sampling edge; returns expected outputs.
  task automatic model_step(input logic [4:0] r, output logic [9:0] exp);
    int win;
    logic [4:0] g;
    win = -1;
    g = '0;
    if (m_phase == 1) begin
      for (int i = 0; i < 4; i++)
        m_wait[i] = r[i] ? ((m_wait[i] + 1 > LIMIT) ? LIMIT : m_wait[i] + 1) : 0;
      m_wait[4] = 0;
      m_phase = 2;
      m_last = 4;
      exp = {5'b10000, 3'b011, 1'b1, 1'b1};
    end else begin
      for (int i = 0; i < 5; i++)
        if (win < 0 && r[i] && i != m_last && m_wait[i] == LIMIT) win = i;
      for (int i = 0; i < 5; i++)
        if (win < 0 && r[i] && i != m_last) win = i;
      for (int i = 0; i < 5; i++) begin
        if (i == win || !r[i]) m_wait[i] = 0;
        else if (i != m_last) m_wait[i] = (m_wait[i] + 1 > LIMIT) ? LIMIT : m_wait[i] + 1;
      end
      if (win == 4) begin
        exp = {5'b00000, 3'b010, 1'b1, 1'b1};
        m_phase = 1;
        m_last = -1;
      end else if (win >= 0) begin
        g[win] = 1'b1;
        exp = {g, code_tab[win], 1'b1, 1'b0};
        m_phase = 0;
        m_last = win;
      end else begin
        exp = 10'b0;
        m_phase = 0;
        m_last = -1;
      end
    end
  endtask

  task automatic test_random;
    logic [4:0] pend;
    logic [9:0] exp;
    pend = '0;
    m_phase = 0;
    m_last = -1;
    for (int i = 0; i < 5; i++) m_wait[i] = 0;
    for (int c = 0; c < 600; c++) begin
      set_req(pend);
      model_step(pend, exp);
      tick;
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL rand_c%0d req=%b obs=%b exp=%b", c, pend, obs(), exp);
      end
      for (int i = 0; i < 5; i++) begin
        if (exp[5+i]) pend[i] = ($urandom_range(3) == 0);
        else if (!pend[i]) pend[i] = ($urandom_range(99) < ((i == 4) ? 8 : 30));
      end
    end
    idle;
  endtask

  initial begin
    set_req(5'b0);
    test_reset;
    test_two_reqs;
    test_md_seq;
    test_starve;
    test_dual_starve;
    test_back_to_back;
    test_random;
    test_reset_md;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
